serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial subtractor, the inverse-direction companion of the combinational full adder. It computes A − B over WIDTH clock cycles, LSB first, through a single full-subtractor cell and a registered borrow. Parallel operands are loaded on a start handshake. The result and final borrow (underflow flag) are presented with a one-cycle done pulse. It sits in the lab arithmetic datapath wherever area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  reset, synchronous, active-high.
start  input  1  request to begin a subtraction; a, b sampled in the same cycle.
a  input  WIDTH  minuend.
b  input  WIDTH  subtrahend.
busy  output  1  high while bits are being processed (SHIFT state).
done  output  1  one-cycle pulse when diff/bout become valid.
diff  output  WIDTH  result A − B modulo 2^WIDTH.
bout  output  1  final borrow; 1 when A < B (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal operand registers, borrow register and bit counter cleared.
  - Reset takes priority over everything, including mid-operation; any in-flight subtraction is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 then
  - latch a into A_sr and b into B_sr;
  - clear the borrow register;
  - set cnt=0;
  - go to SHIFT.
  If start=0, stay in IDLE.
- SHIFT (busy=1), each cycle:
  - Cell inputs x=A_sr[0], y=B_sr[0], bin=borrow.
  - d = x^y^bin; bnext = (~x&y) | (~(x^y)&bin).
  - Result register shifts right with d entering at bit WIDTH-1.
  - A_sr and B_sr shift right, zero-filled.
  - borrow <= bnext; cnt <= cnt+1.
  - When cnt==WIDTH-1 (last bit), go to DONE.
- DONE (one cycle): done=1, busy=0.
  - diff is driven from the completed result register; bout = final borrow.
  - Next state is IDLE, or SHIFT if start=1 in this cycle (back-to-back operation; new operands latched exactly as in IDLE).
- diff and bout hold their values from DONE until the next DONE or a reset. They do not change while the next operation is shifting.
- Latency: start sampled at edge N -> done high during the cycle after edge N+WIDTH; throughput one result per WIDTH+1 cycles.
- start while busy=1 is ignored; it is not queued and a/b changes have no effect.
- Width rules:
  - diff is exactly WIDTH bits; wrap-around is modulo 2^WIDTH.
  - bout is the borrow out of bit WIDTH-1; no signed overflow is computed.
  - cnt is clog2(WIDTH) bits wide.
- Equal operands give diff=0, bout=0. A=0, B=0 is processed normally, taking full latency.

Decomposition:
- Shared package serial_arith_pkg contains:
  - state encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - DEFAULT_WIDTH=8.
- Sub-module full_subtractor_cell (purely combinational): inputs x, y, bin; outputs d, bout. It implements the two equations above and is instantiated once inside serial_subtractor. It is reusable by a later serial adder/subtractor.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, start 1 cycle -> busy high 8 cycles, done pulse 9 cycles after the start edge, diff=0x37, bout=0.
- a=0x10, b=0x20 -> diff=0xF0, bout=1; then a=0xFF, b=0x01 with start held in the DONE cycle -> second result diff=0xFE, bout=0 with no IDLE gap; first diff held until the second done.
- a=0x00, b=0x00 -> diff=0x00, bout=0 after full latency; a=0x00, b=0x01 -> diff=0xFF, bout=1.
- During SHIFT of a=0x80, b=0x01, pulse start with a=0x11, b=0x11 -> ignored; result diff=0x7F, bout=0.
- rst asserted at the 4th SHIFT cycle of a=0xC3, b=0x3C -> next edge: busy=0, done=0, diff=0, bout=0, state IDLE; no done pulse; a subsequent start runs correctly (diff=0x87, bout=0).
- Exhaustive full_subtractor_cell check over all 8 input combinations against d=x^y^bin and bout equation.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  // Controller state encoding shared by the serial datapaths
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Default operand width
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of one bit position
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;
  logic             load;
  logic [WIDTH-1:0] res_shifted;

  full_subtractor_cell u_cell (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Shared decode: final bit position, operand load, and result shifted by one
  always_comb begin
    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    load        = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    res_shifted = WIDTH'({cell_d, res_q} >> 1);
  end

  // Registers, cleared synchronously so an in-flight operation is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: start accepted in IDLE or DONE, SHIFT ends on the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = start ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands, or shift one bit through the cell per cycle
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    if (load) begin
      a_sr_d   = a;
      b_sr_d   = b;
      res_d    = '0;
      borrow_d = 1'b0;
      cnt_d    = '0;
    end else if (state_q == S_SHIFT) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_d    = res_shifted;
      borrow_d = cell_bout;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_d = res_shifted;
        bout_d = cell_bout;
      end
    end
  end

  // Outputs: status from state, results held in their own registers
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
    diff = diff_q;
    bout = bout_q;
  end

endmodule
